// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver of the
// pulse-generator control path.
//   - uart_state_e   : serialiser state encoding (IDLE, START, DATA, STOP)
//   - DATA_BITS      : payload bits per 8N1 frame
//   - FCLK_DEFAULT   : default system clock frequency [Hz]
//   - FUART_DEFAULT  : default baud rate
//   - calc_bit_div() : clocks per bit minus one, shared with the receiver
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS     = 8;
  localparam int FCLK_DEFAULT  = 100000000;
  localparam int FUART_DEFAULT = 9600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit minus one; the result must fit the 16-bit baud counter.
  function automatic int calc_bit_div(input int fclk, input int fuart);
    return (fclk / fuart) - 32'sd1;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Small synchronous byte FIFO feeding the UART serialiser.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-high (empties the FIFO)
//   push  : write din at the tail; ignored while full
//   pop   : drop the head; ignored while empty
//   din   : byte to store
//   dout  : current head byte (combinational view of storage)
//   full  : DEPTH bytes held
//   empty : no bytes held
// Full is taken from the registered count, so a push into a full FIFO is
// refused even when a pop happens on the same edge.
// ---------------------------------------------------------------------------
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == {(AW + 1){1'b0}});
  assign dout  = mem_r[rd_ptr_r];

  // Qualify requests with the pre-edge full/empty flags.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  // Storage array; contents need no reset because count/pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_sender.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_sender
// 8N1 UART transmitter with an input byte FIFO. Bytes are sent LSB first,
// the line idles high, and queued bytes follow each other with no idle gap.
//   clk_Tx  : system clock, rising edge
//   rst     : asynchronous reset, active-high; abandons any frame in flight
//   data_in : byte to queue
//   wr      : write strobe, pushes data_in when the FIFO is not full
//   Tx_out  : registered serial line, idle 1
//   busy    : a frame is on the line
//   full    : FIFO holds DEPTH bytes
//   empty   : FIFO holds no bytes
//   ovf     : sticky, a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_tx_fifo_sender
  import uart_pkg::*;
#(
  parameter int Fclk  = FCLK_DEFAULT,
  parameter int Fuart = FUART_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                 clk_Tx,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr,
  output logic                 Tx_out,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf
);

  localparam logic [15:0] bit_div  = 16'(calc_bit_div(Fclk, Fuart));
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] START = ST_START;
  localparam logic [1:0] DATA  = ST_DATA;
  localparam logic [1:0] STOP  = ST_STOP;

  logic [1:0]           state_r;
  logic [15:0]          baud_cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tx_r;
  logic                 ovf_r;

  logic                 bit_end_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_dout_s;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_Tx),
    .rst   (rst),
    .push  (wr),
    .pop   (pop_s),
    .din   (data_in),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign bit_end_s = (baud_cnt_r == bit_div);
  assign Tx_out    = tx_r;
  assign busy      = (state_r != IDLE);
  assign full      = fifo_full_s;
  assign empty     = fifo_empty_s;
  assign ovf       = ovf_r;

  // Pop the FIFO head when starting from idle or chaining at a stop-bit end.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      STOP: begin
        if (bit_end_s && !fifo_empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: pop_s = 1'b0;
    endcase
  end

  // Sticky overflow flag; full is the pre-edge value, before any same-edge pop.
  always_ff @(posedge clk_Tx or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (wr && fifo_full_s) begin
      ovf_r <= 1'b1;
    end
  end

  // Serialiser FSM with baud counter; the counter restarts on every state entry.
  always_ff @(posedge clk_Tx or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r       <= 1'b1;
          baud_cnt_r <= 16'd0;
          if (!fifo_empty_s) begin
            shift_r <= fifo_dout_s;
            tx_r    <= 1'b0;
            state_r <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            tx_r       <= shift_r[0];
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= 16'd0;
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= 16'd0;
            if (bit_idx_r == LAST_BIT) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              // Next LSB is shift_r[1] before the shift lands.
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              tx_r      <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= 16'd0;
            if (!fifo_empty_s) begin
              // Chain straight into the next start bit.
              shift_r <= fifo_dout_s;
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= 16'd0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo_sender
// Drives byte writes into the transmitter. A transaction-level model keeps
// the queued bytes and the time each frame starts; decoded serial frames are
// compared against the expected frames in order.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo_sender;

  localparam int FCLK       = 1000000;
  localparam int FUART      = 100000;
  localparam int BIT_CLKS   = FCLK / FUART;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  localparam int DEPTH      = 8;

  typedef struct {
    logic [7:0] b;
    int         t;
  } frame_t;

  logic       clk_Tx  = 1'b0;
  logic       rst     = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       wr      = 1'b0;
  logic       Tx_out;
  logic       busy;
  logic       full;
  logic       empty;
  logic       ovf;

  int         checks    = 0;
  int         failures  = 0;
  int         cyc       = 0;
  int         frame_end = 0;
  bit         ovf_m     = 1'b0;
  logic [7:0] mq[$];
  frame_t     sb[$];

  uart_tx_fifo_sender #(
    .Fclk  (FCLK),
    .Fuart (FUART),
    .DEPTH (DEPTH)
  ) dut (
    .clk_Tx  (clk_Tx),
    .rst     (rst),
    .data_in (data_in),
    .wr      (wr),
    .Tx_out  (Tx_out),
    .busy    (busy),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf)
  );

  always #5 clk_Tx = ~clk_Tx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wr      = 1'b1;
    data_in = b;
    @(negedge clk_Tx);
    wr      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((mq.size() != 0 || cyc < frame_end) && n < budget) begin
      @(negedge clk_Tx);
      n = n + 1;
    end
    if (n >= budget) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL idle_timeout actual=%0d required<%0d", n, budget);
    end
  endtask

  // Reference model: a frame starts whenever bytes are queued and the line
  // is free; each frame lasts FRAME_CLKS; a write into DEPTH queued bytes
  // (counted before this edge's pop) is lost.
  initial begin
    int     n_before;
    frame_t f;
    forever begin
      @(posedge clk_Tx);
      cyc = cyc + 1;
      if (rst) begin
        mq.delete();
        sb.delete();
        frame_end = cyc;
        ovf_m     = 1'b0;
      end else begin
        n_before = mq.size();
        if (n_before > 0 && cyc >= frame_end) begin
          f.b = mq.pop_front();
          f.t = cyc;
          sb.push_back(f);
          frame_end = cyc + FRAME_CLKS;
        end
        if (wr) begin
          if (n_before < DEPTH) mq.push_back(data_in);
          else ovf_m = 1'b1;
        end
      end
    end
  end

  // Per-cycle status flags against the model.
  initial begin
    forever begin
      @(negedge clk_Tx);
      if (!rst) begin
        check("empty", {31'd0, empty}, {31'd0, (mq.size() == 0)});
        check("full",  {31'd0, full},  {31'd0, (mq.size() == DEPTH)});
        check("ovf",   {31'd0, ovf},   {31'd0, ovf_m});
        check("busy",  {31'd0, busy},  {31'd0, (cyc < frame_end)});
        if (cyc >= frame_end) check("tx_idle", {31'd0, Tx_out}, 32'd1);
      end
    end
  end

  // Line monitor: decode each frame mid-bit and compare with the scoreboard.
  initial begin
    logic       prev;
    logic [9:0] samp;
    bit         aborted;
    int         s;
    frame_t     e;
    prev = 1'b1;
    forever begin
      @(negedge clk_Tx);
      if (!rst && prev === 1'b1 && Tx_out === 1'b0) begin
        s       = cyc;
        aborted = 1'b0;
        samp    = 10'd0;
        for (int j = 0; j < 10 && !aborted; j++) begin
          for (int w = 0; w < ((j == 0) ? BIT_CLKS / 2 : BIT_CLKS) && !aborted; w++) begin
            @(negedge clk_Tx);
            if (rst) aborted = 1'b1;
          end
          if (!aborted) samp[j] = Tx_out;
        end
        if (!aborted) begin
          if (sb.size() == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL unexpected_frame actual=%0h required=none", samp[8:1]);
          end else begin
            e = sb.pop_front();
            check("start_bit",  {31'd0, samp[0]}, 32'd0);
            check("stop_bit",   {31'd0, samp[9]}, 32'd1);
            check("frame_data", {24'd0, samp[8:1]}, {24'd0, e.b});
            check("frame_time", s, e.t);
          end
        end
      end
      prev = Tx_out;
    end
  end

  // Stimulus
  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst0_tx",    {31'd0, Tx_out}, 32'd1);
    check("rst0_busy",  {31'd0, busy},   32'd0);
    check("rst0_empty", {31'd0, empty},  32'd1);
    check("rst0_full",  {31'd0, full},   32'd0);
    check("rst0_ovf",   {31'd0, ovf},    32'd0);
    repeat (2) @(negedge clk_Tx);
    #2 rst = 1'b0;
    @(negedge clk_Tx);

    // Single byte
    send(8'hA5);
    wait_idle(400);

    // Back-to-back frames
    send(8'h00);
    send(8'hFF);
    wait_idle(600);

    // Fill the FIFO, then overflow it
    for (int i = 1; i <= 9; i++) send(8'(i));
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_ovf0", {31'd0, ovf},  32'd0);
    send(8'h0A);
    check("fill_ovf1", {31'd0, ovf},  32'd1);
    wait_idle(2000);

    // Asynchronous reset in the middle of a low data bit
    send(8'h3C);
    send(8'h11);
    send(8'h22);
    repeat (11) @(negedge clk_Tx);
    check("pre_rst_tx", {31'd0, Tx_out}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_tx",    {31'd0, Tx_out}, 32'd1);
    check("rst_busy",  {31'd0, busy},   32'd0);
    check("rst_empty", {31'd0, empty},  32'd1);
    check("rst_ovf",   {31'd0, ovf},    32'd0);
    repeat (2) @(negedge clk_Tx);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk_Tx);

    // Write into a full FIFO on the edge that pops at the stop-bit end
    for (int i = 1; i <= 9; i++) send(8'(8'h40 + i));
    for (int n = 0; cyc < frame_end - 1 && n < 200; n++) @(negedge clk_Tx);
    check("pp_full_before", {31'd0, full}, 32'd1);
    send(8'hEE);
    check("pp_full_after", {31'd0, full}, 32'd0);
    check("pp_ovf",        {31'd0, ovf},  32'd1);
    check("pp_count",      32'(dut.u_fifo.count_r), 32'(DEPTH - 1));
    wait_idle(2000);

    // Wrap-around: bursts of 4 with random gaps
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) send(8'($urandom));
      repeat ($urandom_range(0, 150)) @(negedge clk_Tx);
    end
    wait_idle(3000);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom));
      else @(negedge clk_Tx);
    end
    wait_idle(3000);
    repeat (5) @(negedge clk_Tx);

    check("end_empty",  {31'd0, empty}, 32'd1);
    check("end_busy",   {31'd0, busy},  32'd0);
    check("sb_drained", sb.size(),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
